// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART-side flush/store logic.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_TX   = 3'd4,
        ST_TERM      = 3'd5,
        ST_WAIT_TERM = 3'd6,
        ST_DONE      = 3'd7
    } tx_flush_state_t;

    localparam logic [7:0] TERM_BYTE_C = 8'h0A;

endpackage
`default_nettype wire

// File: rtl/fsm_tx_bcounter.sv
`default_nettype none
// ============================================================================
// Module   : fsm_tx_bcounter
// Brief    : Loadable remaining-byte down-counter; saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_tx_bcounter #(
    parameter int LEN_W = 9
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [LEN_W-1:0] o_cnt,
    output logic             o_zero,
    output logic             o_last
);

    logic [LEN_W-1:0] r_cnt;

    // Clear wins over load so an abort can never leave a stale count behind.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/fsm_tx_flusher.sv
`default_nettype none
// ============================================================================
// Module   : fsm_tx_flusher
// Brief    : Streams a block of source words to the UART transmitter MSB-first,
//            optionally followed by a terminator byte.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_tx_flusher
    import uart_pkg::*;
#(
    parameter int         WORD_W    = 64,
    parameter int         LEN_W     = 9,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_C
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              word_rd_o,
    input  logic [WORD_W-1:0] word_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    input  logic              tx_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  cpt_o
);

    localparam int BPW   = WORD_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    tx_flush_state_t   r_state;
    logic [WORD_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_tx_data;
    logic              r_word_rd;
    logic              r_busy;
    logic              r_done;

    logic [WORD_W-1:0] w_shreg_next;
    logic              w_launch;
    logic              w_load;
    logic              w_dec;
    logic              w_cnt_zero;
    logic              w_cnt_last;

    assign w_shreg_next = r_shreg << 8;
    assign w_launch     = ((r_state == ST_SEND) || (r_state == ST_TERM)) && !tx_busy_i && !abort_i;
    assign w_load       = (r_state == ST_IDLE) && start_i && !abort_i;
    assign w_dec        = (r_state == ST_WAIT_TX) && tx_done_i && !abort_i && !w_cnt_zero;

    fsm_tx_bcounter #(
        .LEN_W (LEN_W)
    ) u_bcounter (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .i_load   (w_load),
        .i_len    (len_i),
        .i_dec    (w_dec),
        .i_clr    (abort_i),
        .o_cnt    (cpt_o),
        .o_zero   (w_cnt_zero),
        .o_last   (w_cnt_last)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_word_rd <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_word_rd <= 1'b0;
            r_done    <= 1'b0;
            if (abort_i) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start_i) begin
                            r_busy <= 1'b1;
                            if (len_i != '0) begin
                                r_state   <= ST_FETCH;
                                r_word_rd <= 1'b1;
                            end else if (TERM_EN) begin
                                r_state   <= ST_TERM;
                                r_tx_data <= TERM_BYTE;
                            end else begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_FETCH: r_state <= ST_LOAD;
                    ST_LOAD: begin
                        r_shreg   <= word_i;
                        r_idx     <= IDX_W'(BPW - 1);
                        r_tx_data <= word_i[WORD_W-1 -: 8];
                        r_state   <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (!tx_busy_i) r_state <= ST_WAIT_TX;
                    end
                    ST_WAIT_TX: begin
                        if (tx_done_i) begin
                            r_shreg <= w_shreg_next;
                            // Count reaching zero ends the data phase even mid-word.
                            if (w_cnt_last) begin
                                if (TERM_EN) begin
                                    r_state   <= ST_TERM;
                                    r_tx_data <= TERM_BYTE;
                                end else begin
                                    r_state <= ST_DONE;
                                end
                            end else if (r_idx == '0) begin
                                r_state   <= ST_FETCH;
                                r_word_rd <= 1'b1;
                            end else begin
                                r_idx     <= r_idx - IDX_W'(1);
                                r_tx_data <= w_shreg_next[WORD_W-1 -: 8];
                                r_state   <= ST_SEND;
                            end
                        end
                    end
                    ST_TERM: begin
                        if (!tx_busy_i) r_state <= ST_WAIT_TERM;
                    end
                    ST_WAIT_TERM: begin
                        if (tx_done_i) r_state <= ST_DONE;
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word_rd_o  = r_word_rd;
    assign tx_data_o  = r_tx_data;
    assign tx_start_o = w_launch;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: doc/fsm_tx_flusher.md
Name: fsm_tx_flusher

Overview:
Transmit-side byte streamer for the FSM top level. It flushes a block of result data (tag, cipher or wave data) from a word-wide source to the UART transmitter, one byte at a time and MSB-first. It counts the remaining bytes down and can append a terminator byte. It is the counterpart of the store-side byte counting used when data arrives from the UART receiver.

Parameters:
WORD_W, 64, source word width in bits; must be a multiple of 8 (bytes per word BPW = WORD_W/8)
LEN_W, 9, width of the byte-length input and of the remaining-byte counter
TERM_EN, 1, 1 = append the terminator byte after the last data byte
TERM_BYTE, 8'h0A, terminator value

Ports:
clock_i  in  1  main clock
resetb_i  in  1  asynchronous reset, active low
start_i  in  1  start a flush; sampled only in IDLE
abort_i  in  1  synchronous abort; has priority over all other inputs except reset
len_i  in  LEN_W  number of data bytes to flush; sampled together with start_i
word_rd_o  out  1  one-cycle read request to the data source
word_i  in  WORD_W  source word; valid exactly one cycle after word_rd_o
tx_data_o  out  8  byte to the UART transmitter
tx_start_o  out  1  one-cycle pulse launching tx_data_o
tx_busy_i  in  1  UART transmitter is busy
tx_done_i  in  1  one-cycle pulse when the UART transmitter finishes a byte
busy_o  out  1  flush in progress (any state other than IDLE)
done_o  out  1  one-cycle pulse after the last byte (or terminator) has completed
cpt_o  out  LEN_W  remaining data bytes

Behaviour:
- Reset: state IDLE. All outputs are 0 (tx_data_o, tx_start_o, word_rd_o, busy_o, done_o, cpt_o). The shift register and byte index are also cleared. Reset may be applied in any state, including mid-byte.
- States: IDLE, FETCH, LOAD, SEND, WAIT_TX, TERM, WAIT_TERM, DONE.
- IDLE, start_i=1:
  - Latch cpt <= len_i.
  - If len_i != 0, go to FETCH.
  - If len_i == 0, go to TERM when TERM_EN=1, otherwise DONE.
- FETCH: word_rd_o=1 for exactly this cycle, then go to LOAD.
- LOAD: capture word_i into the shift register, set byte index <= BPW-1, go to SEND.
- SEND:
  - tx_data_o = shift register [WORD_W-1 -: 8].
  - If tx_busy_i=0: tx_start_o=1 for this cycle, then go to WAIT_TX.
  - Else: stay in SEND, with no tx_start_o and tx_data_o held stable.
- WAIT_TX:
  - tx_data_o is held stable. Wait for tx_done_i.
  - On tx_done_i: cpt <= cpt-1 and shift the register left by 8.
    - If the new cpt == 0: go to TERM (TERM_EN=1) or DONE.
    - Else if byte index == 0: go to FETCH.
    - Else: decrement the byte index and go to SEND.
- TERM: tx_data_o = TERM_BYTE; same busy gating and tx_start_o pulse as SEND; then go to WAIT_TERM.
- WAIT_TERM: on tx_done_i, go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Latency: from the start_i cycle (len_i != 0, tx idle), word_rd_o rises in cycle +1 and the first tx_start_o in cycle +3. Between tx_done_i and the next tx_start_o there is 1 cycle within a word and 3 cycles across a word boundary.
- Words are fetched only when needed. The number of word_rd_o pulses is ceil(len/BPW); the unused low bytes of the final word are discarded.
- start_i outside IDLE is ignored. tx_done_i outside WAIT_TX/WAIT_TERM is ignored.
- abort_i in any state: next state is IDLE, cpt_o <= 0, no done_o, no further tx_start_o or word_rd_o. A byte already launched completes in the UART; its tx_done_i is ignored.
- cpt_o never underflows; it holds at 0 in TERM, WAIT_TERM, DONE and IDLE after completion.
- Arithmetic is unsigned; len_i up to 2^LEN_W-1 is legal.

Decomposition:
- uart_pkg: the state enum typedef (tx_flush_state_t) and a TERM_BYTE_C default constant.
- Sub-module fsm_tx_bcounter: the loadable, enable-gated remaining-byte down-counter (load, decrement, clear, zero flag).
- The FSM, shift register and byte index stay in fsm_tx_flusher.

Test Plan:
- len=16, words 0x0011223344556677 then 0x8899AABBCCDDEEFF, TERM_EN=1, UART modelled with a 10-cycle tx_done_i. Required: bytes 00,11,...,FF then 0A; exactly 2 word_rd_o pulses; one done_o; cpt_o steps 16 down to 0.
- len=3, word 0xA1B2C3D4E5F60718. Required: bytes A1,B2,C3 then 0A; 1 word_rd_o; D4..18 never sent.
- len=0, TERM_EN=1. Required: only 0A sent; zero word_rd_o; done_o after its tx_done_i. With TERM_EN=0: done_o 2 cycles after start_i and no tx_start_o.
- tx_busy_i held high 5 cycles while in SEND. Required: tx_start_o delayed until busy drops; tx_data_o constant throughout; byte order unchanged.
- abort_i after the 2nd tx_done_i of a len=10 flush. Required: busy_o=0 next cycle, cpt_o=0, no done_o, no further tx_start_o. A new start_i with len=1 then flushes correctly.
- resetb_i asserted during WAIT_TX. Required: all outputs 0 immediately; a start_i pulse while in a busy state (pre-reset) is ignored; after release, the FSM is idle and accepts a new start.
